// File: rtl/vga_rx_decoder.sv
// VGA receiver: recovers pixel coordinates from hsync/vsync, measures line and
// frame lengths, and tracks timing lock through a SEARCH/TRACK/LOCKED FSM.
module vga_rx_decoder #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_ACT = 1'b0
) (
   input  logic        board_clock,
   input  logic        reset_n,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [7:0]  red,
   input  logic [7:0]  green,
   input  logic [7:0]  blue,
   output logic [9:0]  x_val,
   output logic [9:0]  y_val,
   output logic        pixel_valid,
   output logic [7:0]  pix_red,
   output logic [7:0]  pix_green,
   output logic [7:0]  pix_blue,
   output logic        frame_start,
   output logic        locked,
   output logic        h_err,
   output logic        v_err,
   output logic [11:0] h_count_meas,
   output logic [11:0] v_count_meas
);

   localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [11:0] V_TOTAL = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [11:0] V_START = 12'(V_SYNC + V_BP);
   localparam logic [11:0] V_END   = 12'(V_SYNC + V_BP + V_ACTIVE);

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_TRACK,
      ST_LOCKED
   } state_t;

   state_t      r_state;
   logic        r_hs_q, r_vs_q;
   logic [11:0] r_h_cnt, r_v_cnt;
   logic        r_v_pend;
   logic        r_line_bad;
   logic [11:0] r_h_meas, r_v_meas;
   logic [9:0]  r_x_val, r_y_val;
   logic [7:0]  r_red, r_green, r_blue;
   logic        r_valid, r_frame_start, r_locked, r_h_err, r_v_err;

   logic        w_hs_le, w_vs_le, w_frame_evt;
   logic [11:0] w_h_inc, w_v_inc, w_h_next, w_v_next;
   logic        w_h_bad, w_v_meas_bad, w_v_bad, w_frame_clean;
   logic        w_active, w_origin;

   assign w_hs_le     = pix_en && (r_hs_q != SYNC_ACT) && (hsync == SYNC_ACT);
   assign w_vs_le     = pix_en && (r_vs_q != SYNC_ACT) && (vsync == SYNC_ACT);
   // A vsync edge coinciding with an hsync edge closes the frame on that same line.
   assign w_frame_evt = w_hs_le && (r_v_pend || w_vs_le);

   assign w_h_inc  = (r_h_cnt == 12'hFFF) ? r_h_cnt : r_h_cnt + 12'd1;
   assign w_v_inc  = (r_v_cnt == 12'hFFF) ? r_v_cnt : r_v_cnt + 12'd1;
   assign w_h_next = w_hs_le ? 12'd0 : (pix_en ? w_h_inc : r_h_cnt);
   assign w_v_next = w_frame_evt ? 12'd0 : (w_hs_le ? w_v_inc : r_v_cnt);

   assign w_h_bad       = (w_hs_le && (w_h_inc != H_TOTAL))
                        || (pix_en && !w_hs_le && (w_h_inc == H_TOTAL));
   assign w_v_meas_bad  = w_frame_evt && (w_v_inc != V_TOTAL);
   assign w_v_bad       = w_v_meas_bad
                        || (w_hs_le && !w_frame_evt && (w_v_inc == V_TOTAL));
   assign w_frame_clean = w_frame_evt && !w_v_meas_bad && !w_h_bad && !r_line_bad;

   // Position of the sample being taken this cycle, so the hsync sample is pixel 0.
   assign w_active = pix_en
                   && (w_h_next >= H_START) && (w_h_next < H_END)
                   && (w_v_next >= V_START) && (w_v_next < V_END);
   assign w_origin = (w_h_next == H_START) && (w_v_next == V_START);

   always_ff @(posedge board_clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sync registers idle at the deasserted level so a sync already
         // active when reset releases is still seen as a leading edge.
         r_hs_q        <= ~SYNC_ACT;
         r_vs_q        <= ~SYNC_ACT;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_v_pend      <= 1'b0;
         r_line_bad    <= 1'b0;
         r_h_meas      <= '0;
         r_v_meas      <= '0;
         r_x_val       <= '0;
         r_y_val       <= '0;
         r_red         <= '0;
         r_green       <= '0;
         r_blue        <= '0;
         r_valid       <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         if (pix_en) begin
            r_hs_q <= hsync;
            r_vs_q <= vsync;
         end
         r_h_cnt <= w_h_next;
         r_v_cnt <= w_v_next;

         if (w_frame_evt)  r_v_pend <= 1'b0;
         else if (w_vs_le) r_v_pend <= 1'b1;

         if (w_frame_evt)  r_line_bad <= 1'b0;
         else if (w_h_bad) r_line_bad <= 1'b1;

         if (w_hs_le)     r_h_meas <= w_h_inc;
         if (w_frame_evt) r_v_meas <= w_v_inc;

         r_valid       <= w_active;
         r_frame_start <= w_active && w_origin && r_locked;
         if (w_active) begin
            r_x_val <= 10'(w_h_next - H_START);
            r_y_val <= 10'(w_v_next - V_START);
            r_red   <= red;
            r_green <= green;
            r_blue  <= blue;
         end
      end
   end

   always_ff @(posedge board_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_SEARCH;
         r_locked <= 1'b0;
         r_h_err  <= 1'b0;
         r_v_err  <= 1'b0;
      end else begin
         if (w_h_bad) r_h_err <= 1'b1;
         if (w_v_bad) r_v_err <= 1'b1;
         case (r_state)
            ST_SEARCH: begin
               if (w_frame_clean) r_state <= ST_TRACK;
            end
            ST_TRACK: begin
               if (w_h_bad || w_v_bad) begin
                  r_state <= ST_SEARCH;
               end else if (w_frame_clean) begin
                  // Lock entry is the only event besides reset that clears errors.
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                  r_h_err  <= 1'b0;
                  r_v_err  <= 1'b0;
               end
            end
            ST_LOCKED: begin
               if (w_h_bad || w_v_bad) begin
                  r_state  <= ST_SEARCH;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign x_val        = r_x_val;
   assign y_val        = r_y_val;
   assign pixel_valid  = r_valid;
   assign pix_red      = r_red;
   assign pix_green    = r_green;
   assign pix_blue     = r_blue;
   assign frame_start  = r_frame_start;
   assign locked       = r_locked;
   assign h_err        = r_h_err;
   assign v_err        = r_v_err;
   assign h_count_meas = r_h_meas;
   assign v_count_meas = r_v_meas;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder using a scaled-down raster (16x9 totals, 8x4 active)
// so that many complete frames fit in a short run.
module tb_vga_rx_decoder;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;   // 16
   localparam int HST = HS + HB;            // 6
   localparam int VST = VS + VB;            // 4

   logic        board_clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        pix_en = 1'b0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic [7:0]  red = '0, green = '0, blue = '0;
   logic [9:0]  x_val, y_val;
   logic        pixel_valid, frame_start, locked, h_err, v_err;
   logic [7:0]  pix_red, pix_green, pix_blue;
   logic [11:0] h_count_meas, v_count_meas;

   vga_rx_decoder #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_ACT(1'b0)
   ) dut (
      .board_clock (board_clock),
      .reset_n     (reset_n),
      .pix_en      (pix_en),
      .hsync       (hsync),
      .vsync       (vsync),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .x_val       (x_val),
      .y_val       (y_val),
      .pixel_valid (pixel_valid),
      .pix_red     (pix_red),
      .pix_green   (pix_green),
      .pix_blue    (pix_blue),
      .frame_start (frame_start),
      .locked      (locked),
      .h_err       (h_err),
      .v_err       (v_err),
      .h_count_meas(h_count_meas),
      .v_count_meas(v_count_meas)
   );

   always #5 board_clock = ~board_clock;

   typedef struct {
      int lines;
      int short_line;  int short_len;
      int stall_line;  int stall_hpos;
      int rst_line;    int rst_hpos;
      int exp_valid;   int exp_fs;      int exp_locked;
      int exp_herr;    int exp_verr;    int exp_hmeas;  int exp_vmeas;
   } frame_vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   bit aligned  = 1'b0;
   int valid_cnt, fs_cnt, last_x;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] blue_of(input int l, input int p);
      return 8'((l * 7 + p * 3) & 255);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_x"},      x_val, 0);
      check({tag, "_y"},      y_val, 0);
      check({tag, "_valid"},  pixel_valid, 0);
      check({tag, "_pix"},    {pix_red, pix_green, pix_blue}, 0);
      check({tag, "_fs"},     frame_start, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_herr"},   h_err, 0);
      check({tag, "_verr"},   v_err, 0);
      check({tag, "_hmeas"},  h_count_meas, 0);
      check({tag, "_vmeas"},  v_count_meas, 0);
   endtask

   // One pix_en sample at raster position (line l, pixel p), then one idle cycle.
   task automatic do_sample(input int l, input int p, input int stall);
      logic exp_v;
      check("idle_valid", pixel_valid, 0);
      for (int i = 0; i < stall; i++) @(negedge board_clock);
      if (stall > 0) begin
         check("stall_valid", pixel_valid, 0);
         check("stall_x_hold", x_val, last_x);
      end
      hsync  = (p < HS) ? 1'b0 : 1'b1;
      vsync  = (l < VS) ? 1'b0 : 1'b1;
      red    = 8'(p - HST);
      green  = 8'(l - VST);
      blue   = blue_of(l, p);
      pix_en = 1'b1;
      @(negedge board_clock);
      pix_en = 1'b0;
      exp_v  = aligned && (p >= HST) && (p < HST + HA) && (l >= VST) && (l < VST + VA);
      check("pixel_valid", pixel_valid, exp_v);
      if (exp_v) begin
         check("x_val", x_val, p - HST);
         check("y_val", y_val, l - VST);
         check("pix_red", pix_red, 8'(p - HST));
         check("pix_green", pix_green, 8'(l - VST));
         check("pix_blue", pix_blue, blue_of(l, p));
         last_x = p - HST;
      end
      if (pixel_valid) valid_cnt++;
      if (frame_start) begin
         fs_cnt++;
         check("fs_at_origin", {pixel_valid, x_val, y_val}, {1'b1, 20'd0});
      end
      @(negedge board_clock);
   endtask

   task automatic do_reset_mid();
      reset_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge board_clock);
      reset_n = 1'b1;
      aligned = 1'b0;
   endtask

   // Drives a frame from (0,1) through the (0,0) sample that closes it.
   task automatic drive_frame(input frame_vec_t v, input int idx);
      int len;
      valid_cnt = 0;
      fs_cnt    = 0;
      for (int l = 0; l < v.lines; l++) begin
         len = (l == v.short_line) ? v.short_len : HT;
         for (int p = (l == 0) ? 1 : 0; p < len; p++) begin
            if (l == v.rst_line && p == v.rst_hpos) do_reset_mid();
            do_sample(l, p, (l == v.stall_line && p == v.stall_hpos) ? 50 : 0);
            if (l == v.short_line + 1 && p == 0) begin
               check("short_herr", h_err, 1);
               check("short_unlock", locked, 0);
               check("short_hmeas", h_count_meas, v.short_len);
            end
         end
      end
      do_sample(0, 0, 0);
      aligned = 1'b1;
      check($sformatf("f%0d_valid_cnt", idx), valid_cnt, v.exp_valid);
      check($sformatf("f%0d_fs_cnt", idx), fs_cnt, v.exp_fs);
      check($sformatf("f%0d_locked", idx), locked, v.exp_locked);
      check($sformatf("f%0d_herr", idx), h_err, v.exp_herr);
      check($sformatf("f%0d_verr", idx), v_err, v.exp_verr);
      check($sformatf("f%0d_hmeas", idx), h_count_meas, v.exp_hmeas);
      check($sformatf("f%0d_vmeas", idx), v_count_meas, v.exp_vmeas);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      frame_vec_t vecs[13];
      //           lines shL shLen stL stP rL rP  val fs lck he ve hm vm
      vecs[0]  = '{9, -1, 16, -1, -1, -1, -1, 32, 0, 0, 1, 1, 16, 9};  // SEARCH->TRACK
      vecs[1]  = '{9, -1, 16, -1, -1, -1, -1, 32, 0, 1, 0, 0, 16, 9};  // TRACK->LOCKED
      vecs[2]  = '{9, -1, 16, -1, -1, -1, -1, 32, 1, 1, 0, 0, 16, 9};
      vecs[3]  = '{9, -1, 16,  5,  8, -1, -1, 32, 1, 1, 0, 0, 16, 9};  // mid-line stall
      vecs[4]  = '{9,  5, 15, -1, -1, -1, -1, 32, 1, 0, 1, 0, 16, 9};  // short line
      vecs[5]  = '{9, -1, 16, -1, -1, -1, -1, 32, 0, 0, 1, 0, 16, 9};
      vecs[6]  = '{9, -1, 16, -1, -1, -1, -1, 32, 0, 1, 0, 0, 16, 9};  // relock
      vecs[7]  = '{8, -1, 16, -1, -1, -1, -1, 32, 1, 0, 0, 1, 16, 8};  // short frame
      vecs[8]  = '{9, -1, 16, -1, -1, -1, -1, 32, 0, 0, 0, 1, 16, 9};
      vecs[9]  = '{9, -1, 16, -1, -1,  5,  9, 11, 0, 0, 1, 1, 16, 4};  // reset mid-frame
      vecs[10] = '{9, -1, 16, -1, -1, -1, -1, 32, 0, 0, 1, 1, 16, 9};
      vecs[11] = '{9, -1, 16, -1, -1, -1, -1, 32, 0, 1, 0, 0, 16, 9};
      vecs[12] = '{9, -1, 16, -1, -1, -1, -1, 32, 1, 1, 0, 0, 16, 9};

      last_x = 0;
      repeat (3) @(negedge board_clock);
      check_all_zero("reset");
      reset_n = 1'b1;

      // First sample after reset sees both sync edges against a zeroed counter.
      do_sample(0, 0, 0);
      check("pro_hmeas", h_count_meas, 1);
      check("pro_vmeas", v_count_meas, 1);
      check("pro_herr", h_err, 1);
      check("pro_verr", v_err, 1);
      check("pro_locked", locked, 0);
      aligned = 1'b1;

      for (int i = 0; i < 13; i++) drive_frame(vecs[i], i);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
